// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam int WORD_BYTES = 4;

    // Only the byte-offset bits matter; callers pass addr[1:0].
    function automatic logic is_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb & 2'(WORD_BYTES - 1)) == 2'b00;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_grant2.sv
// Two-input round-robin tie-break: on a tie, the requester that did not win last time is picked.
module rr_grant2 (
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic       o_any,
    output logic       o_grant
);

    always_comb begin
        o_any = |i_req;
        if (i_req == 2'b11) begin
            o_grant = ~i_last_grant;
        end else begin
            o_grant = i_req[1];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for a single-port data memory with a combinational read.
// Zero-latency grant from IDLE, bounded burst hold, registered read/error responses.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [1:0]        req_we,
    input  logic [31:0]       req_wdata0,
    input  logic [31:0]       req_wdata1,
    output logic [1:0]        resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int               CNT_W      = 4;
    localparam logic [CNT_W-1:0] BURST_MAX  = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              r_last_grant;
    logic              w_last_grant_nxt;
    logic [CNT_W-1:0]  r_burst_cnt;
    logic [CNT_W-1:0]  w_burst_cnt_nxt;
    logic [1:0]        r_resp_valid;
    logic [31:0]       r_resp_rdata;
    logic              r_resp_err;

    logic              w_rr_any;
    logic              w_rr_grant;
    logic              w_has_owner;
    logic              w_owner;
    logic              w_owner_valid;
    logic              w_other_valid;
    logic              w_aligned;
    logic              w_xfer;
    logic              w_switch;
    logic [ADDR_W-1:0] w_owner_addr;

    rr_grant2 u_rr_grant2 (
        .i_req        (req_valid),
        .i_last_grant (r_last_grant),
        .o_any        (w_rr_any),
        .o_grant      (w_rr_grant)
    );

    // In IDLE the owner is picked combinationally so a request is accepted the cycle it appears.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_has_owner = 1'b0;
        w_owner     = 1'b0;
        if (rst_n) begin
            case (r_state)
                IDLE: begin
                    w_has_owner = w_rr_any;
                    w_owner     = w_rr_grant;
                end
                OWN0: begin
                    w_has_owner = 1'b1;
                    w_owner     = 1'b0;
                end
                OWN1: begin
                    w_has_owner = 1'b1;
                    w_owner     = 1'b1;
                end
                default: begin
                    w_has_owner = 1'b0;
                    w_owner     = 1'b0;
                end
            endcase
        end
    end

    assign w_owner_valid = req_valid[w_owner];
    assign w_other_valid = req_valid[~w_owner];
    assign w_owner_addr  = w_owner ? req_addr1 : req_addr0;
    assign w_aligned     = is_aligned(w_owner_addr[1:0]);
    assign w_xfer        = w_has_owner & w_owner_valid;
    // Counter saturates, so ">=" also covers a waiter that shows up after saturation.
    assign w_switch      = w_xfer & w_other_valid & (r_burst_cnt >= BURST_LAST);

    assign req_ready = w_has_owner ? (w_owner ? 2'b10 : 2'b01) : 2'b00;
    assign mem_addr  = w_has_owner ? w_owner_addr : '0;
    assign mem_wdata = w_has_owner ? (w_owner ? req_wdata1 : req_wdata0) : '0;
    assign mem_we    = w_xfer & req_we[w_owner] & w_aligned;

    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_burst_cnt_nxt  = r_burst_cnt;
        if (w_has_owner) begin
            if (!w_owner_valid) begin
                w_state_nxt      = IDLE;
                w_last_grant_nxt = w_owner;
                w_burst_cnt_nxt  = '0;
            end else if (w_switch) begin
                w_state_nxt      = w_owner ? OWN0 : OWN1;
                w_last_grant_nxt = w_owner;
                w_burst_cnt_nxt  = '0;
            end else begin
                w_state_nxt = w_owner ? OWN1 : OWN0;
                if (r_burst_cnt != BURST_MAX) begin
                    w_burst_cnt_nxt = r_burst_cnt + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_burst_cnt  <= '0;
            r_resp_valid <= 2'b00;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_burst_cnt  <= w_burst_cnt_nxt;
            r_resp_valid <= 2'b00;
            if (w_xfer && (!req_we[w_owner] || !w_aligned)) begin
                r_resp_valid <= w_owner ? 2'b10 : 2'b01;
                r_resp_rdata <= w_aligned ? mem_rdata : 32'h0;
                r_resp_err   <= ~w_aligned;
            end
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table plus burst, streaming and reset sequences.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [31:0] req_addr0 = '0;
    logic [31:0] req_addr1 = '0;
    logic [1:0]  req_we = 2'b00;
    logic [31:0] req_wdata0 = '0;
    logic [31:0] req_wdata1 = '0;
    logic [1:0]  resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .MAX_BURST(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr0  (req_addr0),
        .req_addr1  (req_addr1),
        .req_we     (req_we),
        .req_wdata0 (req_wdata0),
        .req_wdata1 (req_wdata1),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Memory model: combinational read, write on the edge, preloaded with A500_0000 | word index.
    logic [31:0] tb_mem [0:1023];
    logic        mem_loaded = 1'b0;
    assign mem_rdata = tb_mem[mem_addr[11:2]];

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 1024; i++) tb_mem[i] <= 32'hA500_0000 | 32'(i);
            mem_loaded <= 1'b1;
        end else if (mem_we) begin
            tb_mem[mem_addr[11:2]] <= mem_wdata;
        end
    end

    // A raised request must stay up until it is accepted.
    logic [1:0] pend = 2'b00;
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++)
                if (pend[i] && !req_valid[i]) $error("request %0d withdrawn before ready", i);
            pend <= req_valid & ~req_ready;
        end else begin
            pend <= 2'b00;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  we;
        logic [31:0] addr0;
        logic [31:0] addr1;
        logic [31:0] wdata0;
        logic [31:0] wdata1;
        logic [1:0]  exp_ready;
        logic        exp_we;
        logic [1:0]  exp_rv;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [1:0] valid, input logic [1:0] we,
                                input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [1:0] e_rdy, input logic e_we,
                                input logic [1:0] e_rv, input logic [31:0] e_rd, input logic e_err);
        vec_t v;
        v = '{valid, we, a0, a1, d0, d1, e_rdy, e_we, e_rv, e_rd, e_err};
        return v;
    endfunction

    // Drive one row just after the edge; compare outputs at the following falling edge.
    task automatic apply_vec(input vec_t v, input int row);
        @(posedge clk);
        #1;
        req_valid  = v.valid;
        req_we     = v.we;
        req_addr0  = v.addr0;
        req_addr1  = v.addr1;
        req_wdata0 = v.wdata0;
        req_wdata1 = v.wdata1;
        @(negedge clk);
        check($sformatf("row%0d_ready", row), 32'(req_ready), 32'(v.exp_ready));
        check($sformatf("row%0d_mem_we", row), 32'(mem_we), 32'(v.exp_we));
        check($sformatf("row%0d_resp_valid", row), 32'(resp_valid), 32'(v.exp_rv));
        if (v.exp_rv != 2'b00) begin
            check($sformatf("row%0d_rdata", row), resp_rdata, v.exp_rdata);
            check($sformatf("row%0d_err", row), 32'(resp_err), 32'(v.exp_err));
        end
    endtask

    // Per-cycle expected acceptor for stream(): -1 none, 0 or 1.
    int exp_acc[$];

    task automatic stream(input string tag, input int tot0, input int tot1, input int start0,
                          input int base0, input int base1, input int budget);
        int n0 = 0;
        int n1 = 0;
        int cyc = 0;
        int acc;
        int r;
        int q_req[$];
        logic [31:0] q_data[$];
        logic [31:0] exp_d;
        while ((n0 < tot0 || n1 < tot1 || q_req.size() != 0) && cyc < budget) begin
            @(posedge clk);
            #1;
            req_valid = {n1 < tot1, (n0 < tot0) && (cyc >= start0)};
            req_we    = 2'b00;
            req_addr0 = 32'(base0 + 4 * n0);
            req_addr1 = 32'(base1 + 4 * n1);
            @(negedge clk);
            if (resp_valid != 2'b00) begin
                if (q_req.size() == 0) begin
                    check({tag, "_extra_resp"}, 32'(resp_valid), 32'h0);
                end else begin
                    r     = q_req.pop_front();
                    exp_d = q_data.pop_front();
                    check({tag, "_resp_owner"}, 32'(resp_valid), (r == 0) ? 32'h1 : 32'h2);
                    check({tag, "_resp_data"}, resp_rdata, exp_d);
                end
            end
            acc = -1;
            if (req_valid[0] && req_ready[0]) acc = 0;
            else if (req_valid[1] && req_ready[1]) acc = 1;
            if (cyc < exp_acc.size())
                check($sformatf("%s_grant_c%0d", tag, cyc), acc, exp_acc[cyc]);
            if (acc == 0) begin
                q_req.push_back(0);
                q_data.push_back(32'hA500_0000 | 32'((base0 + 4 * n0) >> 2));
                n0++;
            end else if (acc == 1) begin
                q_req.push_back(1);
                q_data.push_back(32'hA500_0000 | 32'((base1 + 4 * n1) >> 2));
                n1++;
            end
            cyc++;
        end
        check({tag, "_complete"}, 32'((n0 == tot0) && (n1 == tot1) && (q_req.size() == 0)), 32'h1);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(negedge clk);
        check({tag, "_no_dup_resp"}, 32'(resp_valid), 32'h0);
    endtask

    initial begin
        // Test 1: write then read-back by requester 0
        vecs.push_back(mk(2'b01, 2'b01, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 2'b01, 1'b1, 2'b00, 32'h0, 1'b0));
        vecs.push_back(mk(2'b01, 2'b00, 32'h100, 32'h0, 32'h0, 32'h0, 2'b01, 1'b0, 2'b00, 32'h0, 1'b0));
        vecs.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b01, 1'b0, 2'b01, 32'hDEADBEEF, 1'b0));
        vecs.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 2'b00, 32'h0, 1'b0));
        // Test 4: misaligned write by requester 1, then aligned read-back
        vecs.push_back(mk(2'b10, 2'b10, 32'h0, 32'h102, 32'h0, 32'h12345678, 2'b10, 1'b0, 2'b00, 32'h0, 1'b0));
        vecs.push_back(mk(2'b10, 2'b00, 32'h0, 32'h100, 32'h0, 32'h0, 2'b10, 1'b0, 2'b10, 32'h0, 1'b1));
        vecs.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b10, 1'b0, 2'b10, 32'hDEADBEEF, 1'b0));
        vecs.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 2'b00, 32'h0, 1'b0));
        // Test 6: burst of writes by 0 ends at 0x200, then 1 reads 0x200 on the next cycle
        vecs.push_back(mk(2'b11, 2'b01, 32'h204, 32'h200, 32'h11111111, 32'h0, 2'b01, 1'b1, 2'b00, 32'h0, 1'b0));
        vecs.push_back(mk(2'b11, 2'b01, 32'h208, 32'h200, 32'h22222222, 32'h0, 2'b01, 1'b1, 2'b00, 32'h0, 1'b0));
        vecs.push_back(mk(2'b11, 2'b01, 32'h20C, 32'h200, 32'h33333333, 32'h0, 2'b01, 1'b1, 2'b00, 32'h0, 1'b0));
        vecs.push_back(mk(2'b11, 2'b01, 32'h200, 32'h200, 32'h55AA55AA, 32'h0, 2'b01, 1'b1, 2'b00, 32'h0, 1'b0));
        vecs.push_back(mk(2'b10, 2'b00, 32'h0, 32'h200, 32'h0, 32'h0, 2'b10, 1'b0, 2'b00, 32'h0, 1'b0));
        vecs.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b10, 1'b0, 2'b10, 32'h55AA55AA, 1'b0));
        vecs.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 2'b00, 32'h0, 1'b0));
        // Post-reset rows: tie goes to 0, memory contents survived reset
        vecs.push_back(mk(2'b11, 2'b00, 32'h100, 32'h204, 32'h0, 32'h0, 2'b01, 1'b0, 2'b00, 32'h0, 1'b0));
        vecs.push_back(mk(2'b10, 2'b00, 32'h0, 32'h204, 32'h0, 32'h0, 2'b01, 1'b0, 2'b01, 32'hDEADBEEF, 1'b0));
        vecs.push_back(mk(2'b10, 2'b00, 32'h0, 32'h204, 32'h0, 32'h0, 2'b10, 1'b0, 2'b00, 32'h0, 1'b0));
        vecs.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b10, 1'b0, 2'b10, 32'h11111111, 1'b0));
        vecs.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 2'b00, 32'h0, 1'b0));

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", 32'(resp_err), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) apply_vec(vecs[i], i);

        // Test 2: both streaming, grants 4/4/4
        exp_acc = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, -1};
        stream("burst", 8, 4, 0, 32'h300, 32'h600, 40);
        // Test 3a: requester 1 alone, 10 accepts in 10 cycles
        exp_acc = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, -1};
        stream("solo", 0, 10, 0, 32'h300, 32'h600, 40);
        // Test 3b: requester 0 shows up at cycle 6 while 1 holds a saturated burst
        exp_acc = '{1, 1, 1, 1, 1, 1, 1, 0, -1, 1, 1, 1, -1};
        stream("late", 1, 10, 6, 32'h300, 32'h600, 40);

        // Test 5: reset in the cycle after a read accept drops the response
        @(posedge clk);
        #1;
        req_valid = 2'b01;
        req_we    = 2'b00;
        req_addr0 = 32'h100;
        @(negedge clk);
        check("mid_rst_accept", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        req_valid = 2'b00;
        @(negedge clk);
        check("mid_rst_resp_dropped", 32'(resp_valid), 32'h0);
        check("mid_rst_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        check("mid_rst_resp_hold", 32'(resp_valid), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_resp", 32'(resp_valid), 32'h0);

        for (int i = 15; i < 20; i++) apply_vec(vecs[i], i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port data memory, which has a word-indexed array, a combinational read and a write on the clock edge.
- Shares the memory between the core load/store unit (requester 0) and the loader/debug port (requester 1).
- Uses a valid/ready handshake on each requester and registered read responses.
- Grants round-robin with a bounded burst hold, and flags misaligned accesses.

Parameters:
- ADDR_W, 32, byte address width. Word index is addr[ADDR_W-1:2].
- MAX_BURST, 4, maximum consecutive accepted transfers by one owner while the other requester is waiting. Legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- req_valid  in  2  per-requester request valid, bit i = requester i.
- req_ready  out  2  per-requester accept. A transfer occurs when valid&ready are both high on a clk edge.
- req_addr0 / req_addr1  in  ADDR_W  byte address.
- req_we  in  2  1 = write, 0 = read.
- req_wdata0 / req_wdata1  in  32  write data.
- resp_valid  out  2  one-cycle pulse: read data or error response for requester i.
- resp_rdata  out  32  read data. Shared by both requesters; qualified by resp_valid.
- resp_err  out  1  the response is for a misaligned access.
- mem_addr  out  ADDR_W  address to the memory (the memory indexes with [ADDR_W-1:2]).
- mem_we  out  1  memory write enable.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  combinational read data from the memory.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, last_grant=1 (requester 0 wins the first tie), burst_cnt=0. All outputs are 0: req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata.
- FSM states:
  - IDLE: no owner.
  - OWN0 / OWN1: requester 0 / 1 owns the memory.
- IDLE transitions:
  - Single valid requester: go to its OWN state.
  - Both valid: go to OWN of ~last_grant.
  - The grant decision is made combinationally in the same cycle: ready asserts in the cycle valid is first seen (zero-latency accept from IDLE).
- OWN state behaviour:
  - req_ready = owner bit only. mem_addr, mem_wdata and mem_we are muxed from the owner.
  - mem_we = owner_valid & owner_we & aligned. It never asserts for a misaligned address.
  - On each accepted transfer, burst_cnt increments and saturates at MAX_BURST.
- OWN state exits:
  - Owner valid low: go to IDLE, last_grant=owner, burst_cnt=0.
  - Owner valid high, other valid, burst_cnt==MAX_BURST-1 at an accept: after this transfer, switch to OWN of the other requester. last_grant=old owner, burst_cnt=0.
  - Other requester not valid: the owner keeps ownership indefinitely. The counter holds at saturation and a switch occurs on the next accept once the other requester raises valid.
- Read response:
  - Accepted read at edge N: resp_valid[owner]=1 for the cycle after edge N, resp_rdata = mem_rdata sampled at edge N, resp_err=0.
  - Back-to-back reads give back-to-back responses.
- Write: data is committed by the memory on edge N. No response for an aligned write.
- Misaligned access (addr[1:0]!=0), read or write: accepted, no memory write, resp_valid pulse with resp_err=1 and resp_rdata=0.
- Simultaneous events:
  - A requester switch and a pending response of the old owner coexist. The response still goes to the old owner's resp_valid bit.
  - Valid falling without acceptance is not allowed. The bench asserts that a request, once raised, is held stable until ready.
- Reset mid-transfer: any pending response is dropped and does not appear after reset deassertion. Memory contents are untouched.
- No combinational path from mem_rdata to any output other than through the response register.

Decomposition:
- Shared package dmem_pkg:
  - typedef arb_state_t {IDLE, OWN0, OWN1}
  - localparam WORD_BYTES=4
  - function is_aligned(addr)
- One sub-module: rr_grant2, a 2-input round-robin tie-break from last_grant. Combinational. All FSM and burst logic stays in dmem_arbiter.

Test Plan:
- Reset, then requester 0 writes 0xDEADBEEF to 0x100, then reads 0x100 -> ready in the same cycle, mem_we for one cycle, resp_valid[0] one cycle after the read accept with rdata 0xDEADBEEF, resp_err=0.
- Both requesters valid from reset, streaming reads (MAX_BURST=4) -> grants: 4 to requester 0, then 4 to requester 1, then 4 to requester 0. Response order matches the grant order with no lost or duplicated responses.
- Only requester 1 streams 10 reads -> continuous ownership with 10 accepts in 10 cycles. Requester 0 raises valid at cycle 6 -> requester 0 gets the next slot after the accept that follows.
- Requester 1 writes to 0x102 -> no mem_we; resp_valid[1]=1, resp_err=1, rdata=0. A subsequent read of 0x100 returns the earlier data unchanged.
- rst_n low in the cycle after a read accept -> resp_valid stays 0 through and after reset. After release, state=IDLE and requester 0 wins a tie.
- Write and read to the same address on consecutive cycles by different owners (0 writes 0x55AA55AA, 1 reads) -> requester 1 gets 0x55AA55AA.
